// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_redirect_unit_pkg: shared state encoding, NOP opcode and flag indices for the fetch stage
package fetch_redirect_unit_pkg;
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;
  localparam logic [7:0] NOP = 8'h00;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_P = 3;
endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: stage-3 control, flag, memory and fetch-output bundle
// FETCH_PERF_CNT_EN adds the taken_cnt/stall_cnt outputs.
interface fetch_redirect_unit_if #(parameter int ADDR_W = 16);
  logic BB3, EFL, LPC;
  logic [2:0] fl_sel;
  logic [3:0] flags;
  logic [ADDR_W-1:0] target;
  logic [7:0] imem_data;
  logic [ADDR_W-1:0] pc;
  logic [7:0] opcode;
  logic opcode_valid, redirect;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] taken_cnt, stall_cnt;
  modport master (output BB3, EFL, LPC, fl_sel, flags, target, imem_data,
                  input pc, opcode, opcode_valid, redirect, taken_cnt, stall_cnt);
  modport slave (input BB3, EFL, LPC, fl_sel, flags, target, imem_data,
                 output pc, opcode, opcode_valid, redirect, taken_cnt, stall_cnt);
`else
  modport master (output BB3, EFL, LPC, fl_sel, flags, target, imem_data,
                  input pc, opcode, opcode_valid, redirect);
  modport slave (input BB3, EFL, LPC, fl_sel, flags, target, imem_data,
                 output pc, opcode, opcode_valid, redirect);
`endif
endinterface

// File: rtl/fetch_redirect_unit_cond_eval.sv
// fetch_redirect_unit_cond_eval: selects a flag by fl_sel[2:1] and compares it with the polarity bit fl_sel[0]
module fetch_redirect_unit_cond_eval (
  input  logic [2:0] fl_sel_i,
  input  logic [3:0] flags_i,
  output logic       cond_o
);
  assign cond_o = flags_i[fl_sel_i[2:1]] ~^ fl_sel_i[0];
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: PC owner and opcode fetch with hold, conditional redirect and NOP flush
// Optional FETCH_PERF_CNT_EN: saturating taken-redirect and hold-cycle counters.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FLUSH_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  fetch_redirect_unit_if.slave bus
);
  state_e state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0] opcode_q;
  logic valid_q, redirect_q, cond, take;
  logic [2:0] cnt_q;
  fetch_redirect_unit_cond_eval u_cond (.fl_sel_i(bus.fl_sel), .flags_i(bus.flags), .cond_o(cond));
  assign take = bus.LPC & (~bus.EFL | cond);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      opcode_q <= NOP;
      valid_q <= 1'b0;
      redirect_q <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == FLUSH) begin
      redirect_q <= 1'b0;
      state_q <= (cnt_q == '0) ? RUN : FLUSH;
      cnt_q <= (cnt_q == '0) ? cnt_q : cnt_q - 3'd1;
    end else if (take) begin
      state_q <= FLUSH;
      pc_q <= bus.target;
      opcode_q <= NOP;
      valid_q <= 1'b0;
      redirect_q <= 1'b1;
      cnt_q <= 3'(FLUSH_DEPTH - 1);
    end else if (bus.BB3) begin
      state_q <= HOLD;
      redirect_q <= 1'b0;
    end else begin
      state_q <= RUN;
      pc_q <= pc_q + ADDR_W'(1);
      opcode_q <= bus.imem_data;
      valid_q <= 1'b1;
      redirect_q <= 1'b0;
    end
  assign bus.pc = pc_q;
  assign bus.opcode = opcode_q;
  assign bus.opcode_valid = valid_q;
  assign bus.redirect = redirect_q;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] taken_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_q + {15'd0, take && state_q != FLUSH && taken_cnt_q != 16'hFFFF};
      stall_cnt_q <= stall_cnt_q + {15'd0, state_q == HOLD && stall_cnt_q != 16'hFFFF};
    end
  assign bus.taken_cnt = taken_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed and random stimulus against an edge-counting reference model
module tb_fetch_redirect_unit;
  localparam int D = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_redirect_unit_if #(.ADDR_W(16)) bus ();
  fetch_redirect_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.imem_data = bus.pc[7:0];
  int n_cmp = 0, n_err = 0;
  int edge_n, resume_edge;
  logic [15:0] m_pc;
  logic [7:0] m_op;
  logic m_valid, m_redir, in_hold;
  int m_taken, m_stall;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    edge_n = 0; resume_edge = 0; m_pc = 16'h0000; m_op = 8'h00;
    m_valid = 0; m_redir = 0; in_hold = 0; m_taken = 0; m_stall = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
    chk({tag, ".opcode"}, 32'(bus.opcode), 32'(m_op));
    chk({tag, ".valid"}, 32'(bus.opcode_valid), 32'(m_valid));
    chk({tag, ".redirect"}, 32'(bus.redirect), 32'(m_redir));
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".taken_cnt"}, 32'(bus.taken_cnt), 32'(m_taken));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
`endif
  endtask
  task automatic step(input string tag, input logic bb3, input logic efl, input logic lpc,
                      input logic [2:0] fs, input logic [3:0] fl, input logic [15:0] tg);
    bit taken;
    @(negedge clk);
    bus.BB3 = bb3; bus.EFL = efl; bus.LPC = lpc; bus.fl_sel = fs; bus.flags = fl; bus.target = tg;
    @(posedge clk);
    edge_n++;
    if (in_hold && m_stall < 65535) m_stall++;
    in_hold = 0;
    m_redir = 0;
    if (edge_n >= resume_edge) begin
      taken = lpc && (!efl || (((fl >> fs[2:1]) & 4'd1) == 4'(fs[0])));
      if (taken) begin
        m_pc = tg; m_op = 8'h00; m_valid = 0; m_redir = 1;
        resume_edge = edge_n + D + 1;
        if (m_taken < 65535) m_taken++;
      end else if (bb3) begin
        in_hold = 1;
      end else begin
        m_op = m_pc[7:0]; m_pc = m_pc + 16'd1; m_valid = 1;
      end
    end
    #1 check_all(tag);
  endtask
  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 3'd0, 4'd0, 16'd0);
  endtask
  initial begin
    bus.BB3 = 0; bus.EFL = 0; bus.LPC = 0; bus.fl_sel = 0; bus.flags = 0; bus.target = 0;
    model_reset();
    #12 check_all("reset");
    @(posedge clk); #2 rst_n = 1;
    run("freerun", 16);
    chk("at_0x10", 32'(bus.pc), 32'h10);
    for (int i = 0; i < 3; i++) step("hold", 1, 0, 0, 3'd0, 4'd0, 16'd0);
    run("resume", 3);
    step("lpc_uncond", 0, 0, 1, 3'd0, 4'd0, 16'h0200);
    run("flush1", 5);
    step("cond_c0", 0, 1, 1, 3'b001, 4'b0000, 16'h0300);
    run("cond_c0_run", 2);
    step("cond_c1", 0, 1, 1, 3'b001, 4'b0001, 16'h0300);
    run("cond_c1_run", 5);
    step("lpc_bb3_false", 1, 1, 1, 3'b011, 4'b0000, 16'h0400);
    step("lpc_bb3_true", 1, 1, 1, 3'b011, 4'b0010, 16'h0400);
    step("lpc_in_flush", 0, 0, 1, 3'd0, 4'd0, 16'h0500);
    step("bb3_in_flush", 1, 0, 1, 3'd0, 4'd0, 16'h0600);
    run("after_flush", 4);
    step("to_wrap", 0, 0, 1, 3'd0, 4'd0, 16'hFFFE);
    run("wrap", 6);
    for (int i = 0; i < 400; i++)
      step("random", $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 5) == 0,
           3'($urandom), 4'($urandom), 16'($urandom));
    step("pre_reset_take", 0, 0, 1, 3'd0, 4'd0, 16'h1234);
    #3 rst_n = 0;
    model_reset();
    #1 check_all("reset_mid_flush");
    @(posedge clk); #2 rst_n = 1;
    run("post_reset", 4);
    for (int i = 0; i < 3; i++) step("hold2", 1, 0, 0, 3'd0, 4'd0, 16'd0);
    step("take2", 0, 0, 1, 3'd0, 4'd0, 16'h0042);
    run("tail", 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
